// File: rtl/riscv_regfile.sv
// ---------------------------------------------------------------------------
// riscv_regfile
//   Integer register file x0..x31 (64-bit) with two combinational read ports,
//   one write-back port and a self-clearing initialisation sweep.
//   After rst_n deasserts, a 31-cycle sweep zeroes x1..x31. rf_ready rises
//   on the edge that clears x31. Until then, writes are dropped and reads
//   return zero.
//
//   Configuration macro: RISCV_RF_BYPASS_EN
//     When defined, a write in flight is forwarded to a read port whose
//     address matches it, in the same cycle.
//     When undefined (default), reads return the stored value, so the write
//     becomes visible on the next cycle.
//
//   Ports
//     clk         in   1   core clock, all state updates on posedge
//     rst_n       in   1   asynchronous active-low reset
//     rs1_addr    in   5   read port 1 address
//     rs1_data    out  64  read port 1 data (combinational)
//     rs2_addr    in   5   read port 2 address
//     rs2_data    out  64  read port 2 data (combinational)
//     wb_we       in   1   write-back enable
//     wb_rd_addr  in   5   write-back destination register
//     wb_data     in   64  write-back data
//     rf_ready    out  1   initialisation done, writes accepted
// ---------------------------------------------------------------------------
module riscv_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_addr,
    output logic [63:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [63:0] rs2_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd_addr,
    input  logic [63:0] wb_data,
    output logic        rf_ready
);

    localparam int unsigned XLEN     = 64;
    localparam int unsigned AW       = 5;
    localparam int unsigned LAST_REG = 31;

    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_next_state;
    logic [AW-1:0]   r_clr_idx;
    logic [AW-1:0]   w_clr_idx_next;
    logic            r_rf_ready;
    logic            w_clr_we;
    logic            w_wb_we;

    // x0 has no storage; entries are deliberately not reset
    logic [XLEN-1:0] r_mem [1:LAST_REG];

    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    // State register, clear counter and ready flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_clr_idx  <= AW'(1);
            r_rf_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_clr_idx  <= w_clr_idx_next;
            r_rf_ready <= (w_next_state == READY);
        end
    end

    // Next-state and sweep control
    always_comb begin
        w_next_state   = r_state;
        w_clr_idx_next = r_clr_idx;
        w_clr_we       = 1'b0;
        case (r_state)
            INIT: begin
                w_clr_we = 1'b1;
                // Counter stops at the last entry instead of wrapping to x0
                if (r_clr_idx == AW'(LAST_REG)) begin
                    w_next_state = READY;
                end else begin
                    w_clr_idx_next = r_clr_idx + AW'(1);
                end
            end
            READY: begin
                w_next_state = READY;
            end
            default: begin
                w_next_state = INIT;
            end
        endcase
    end

    // Architectural write: only once ready, never to x0
    assign w_wb_we = wb_we && r_rf_ready && (wb_rd_addr != AW'(0));

    // Storage: the sweep has priority; write-back is ignored during INIT
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_wb_we) begin
            r_mem[wb_rd_addr] <= wb_data;
        end
    end

`ifdef RISCV_RF_BYPASS_EN
    logic w_byp_ok;
    assign w_byp_ok = w_wb_we;
`endif

    // Read ports: zero for x0 and whenever not ready (covers reset and INIT)
    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (r_rf_ready && (rs1_addr != AW'(0))) begin
            w_rs1_data = r_mem[rs1_addr];
        end
        if (r_rf_ready && (rs2_addr != AW'(0))) begin
            w_rs2_data = r_mem[rs2_addr];
        end
`ifdef RISCV_RF_BYPASS_EN
        if (w_byp_ok && (rs1_addr == wb_rd_addr)) begin
            w_rs1_data = wb_data;
        end
        if (w_byp_ok && (rs2_addr == wb_rd_addr)) begin
            w_rs2_data = wb_data;
        end
`endif
    end

    assign rs1_data = w_rs1_data;
    assign rs2_data = w_rs2_data;
    assign rf_ready = r_rf_ready;

endmodule

// File: tb/tb_riscv_regfile.sv
// ---------------------------------------------------------------------------
// tb_riscv_regfile
//   Directed testbench for riscv_regfile with hand-computed expected values.
//   Inputs change just after negedge. Outputs are sampled 1 time unit later,
//   so every sample is taken away from the active posedge.
// ---------------------------------------------------------------------------
module tb_riscv_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [63:0] rs1_data;
    logic [4:0]  rs2_addr;
    logic [63:0] rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd_addr;
    logic [63:0] wb_data;
    logic        rf_ready;

    int n_checks;
    int n_pass;

    riscv_regfile u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .wb_we      (wb_we),
        .wb_rd_addr (wb_rd_addr),
        .wb_data    (wb_data),
        .rf_ready   (rf_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock: through posedge, land on the next negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] rd, input logic [63:0] d);
        wb_we      = 1'b1;
        wb_rd_addr = rd;
        wb_data    = d;
        step();
        wb_we      = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a1, input logic [63:0] e1,
                          input logic [4:0] a2, input logic [63:0] e2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
        check({tag, "_rs1"}, rs1_data, e1);
        check({tag, "_rs2"}, rs2_data, e2);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b1;
        rs1_addr   = 5'd5;
        rs2_addr   = 5'd0;
        wb_we      = 1'b0;
        wb_rd_addr = 5'd0;
        wb_data    = 64'h0;
        #1 rst_n   = 1'b0;

        // Reset state
        step();
        step();
        #1;
        check("rst_ready", 64'(rf_ready), 64'h0);
        check("rst_rs1",   rs1_data, 64'h0);

        // First sweep; an INIT-time write to x9 in cycle 10 must be dropped
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            if (k == 10) begin
                wb_we      = 1'b1;
                wb_rd_addr = 5'd9;
                wb_data    = 64'hABCD_0000_0000_0009;
            end else begin
                wb_we = 1'b0;
            end
            rs1_addr = 5'd5;
            #1;
            check($sformatf("init_rs1_c%0d", k), rs1_data, 64'h0);
            step();
            check($sformatf("init_ready_c%0d", k), 64'(rf_ready), (k == 31) ? 64'h1 : 64'h0);
        end
        wb_we = 1'b0;

        rd_chk("x9_after_init", 5'd9, 64'h0, 5'd0, 64'h0);

        // Write x7 then read it on both ports
        wr(5'd7, 64'hDEAD_BEEF_0123_4567);
        rd_chk("x7_rd", 5'd7, 64'hDEAD_BEEF_0123_4567, 5'd7, 64'hDEAD_BEEF_0123_4567);

        // Write to x0 has no effect
        wr(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_chk("x0_rd", 5'd0, 64'h0, 5'd0, 64'h0);
        rd_chk("x0_side", 5'd7, 64'hDEAD_BEEF_0123_4567, 5'd1, 64'h0);

        // Same-cycle write/read of x3
        wr(5'd3, 64'h11);
        wb_we      = 1'b1;
        wb_rd_addr = 5'd3;
        wb_data    = 64'h55;
`ifdef RISCV_RF_BYPASS_EN
        rd_chk("x3_same", 5'd4, 64'h0, 5'd3, 64'h55);
`else
        rd_chk("x3_same", 5'd4, 64'h0, 5'd3, 64'h11);
`endif
        step();
        wb_we = 1'b0;
        rd_chk("x3_next", 5'd3, 64'h55, 5'd3, 64'h55);

        // Fill all registers with their index, read back
        for (int i = 1; i <= 31; i++) begin
            wr(5'(i), 64'(i));
        end
        for (int i = 1; i <= 31; i++) begin
            rd_chk($sformatf("fill_x%0d", i), 5'(i), 64'(i), 5'(32 - i), 64'(32 - i));
        end

        // One-cycle reset, then writes hammered through the whole sweep
        rst_n    = 1'b0;
        rs1_addr = 5'd5;
        #1;
        check("rst2_rs1",   rs1_data, 64'h0);
        check("rst2_ready", 64'(rf_ready), 64'h0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            wb_we      = 1'b1;
            wb_rd_addr = 5'(k);
            wb_data    = 64'hFFFF_0000_0000_0000 | 64'(k);
            step();
            check($sformatf("init2_ready_c%0d", k), 64'(rf_ready), (k == 31) ? 64'h1 : 64'h0);
        end
        wb_we = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            rd_chk($sformatf("clr_x%0d", i), 5'(i), 64'h0, 5'(32 - i), 64'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/riscv_regfile.md
RISCV_REGFILE -- requirements
Module: riscv_regfile

Interface
REQ-001 The block SHALL have a single clock domain and an asynchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  core clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 rs1_addr  input  5  read port 1 address, driven by the EX1 stage.
REQ-005 rs1_data  output  64  read port 1 data, combinational from rs1_addr.
REQ-006 rs2_addr  input  5  read port 2 address, driven by the EX1 stage.
REQ-007 rs2_data  output  64  read port 2 data, combinational from rs2_addr.
REQ-008 wb_we  input  1  write-back enable.
REQ-009 wb_rd_addr  input  5  write-back destination register.
REQ-010 wb_data  input  64  write-back data, already sign-extended for W-ops upstream.
REQ-011 rf_ready  output  1  high when initialisation has finished and writes are accepted.

Function
REQ-012 Storage SHALL be 31 x 64-bit entries for x1..x31; x0 SHALL have no storage and SHALL always read 64'h0.
REQ-013 Reads SHALL be combinational, zero-cycle latency, so EX1 samples data on the same edge it presents the address.
REQ-014 Both read ports SHALL be independent; equal addresses SHALL return identical data.
REQ-015 Write SHALL occur at posedge when wb_we=1, rf_ready=1 and wb_rd_addr!=0; the value SHALL be visible on read ports from the following cycle.
REQ-016 Writes with wb_rd_addr=0 SHALL be discarded with no side effect.
REQ-017 Init FSM states SHALL be INIT and READY, with a 5-bit clear counter clr_idx.
REQ-018 INIT: each posedge SHALL write 64'h0 to entry clr_idx and increment clr_idx, starting from 1.
REQ-019 INIT->READY SHALL occur on the posedge that clears entry 31; rf_ready SHALL go high on that same edge, i.e. 31 posedges after rst_n deasserts.
REQ-020 READY SHALL be terminal until the next rst_n assertion.
REQ-021 During INIT, wb_we SHALL be ignored (write dropped) and both read ports SHALL return 64'h0 regardless of address.
REQ-022 clr_idx SHALL NOT wrap; it is held once READY is reached.

Reset
REQ-023 rst_n assertion SHALL immediately force state=INIT, clr_idx=1 and rf_ready=0.
REQ-024 Storage entries SHALL have no reset; their contents are guaranteed only by the INIT sweep.
REQ-025 Reset asserted mid-INIT or mid-READY SHALL restart the full 31-cycle sweep after deassertion; prior contents are unobservable (reads forced to zero).
REQ-026 rs1_data and rs2_data SHALL read 64'h0 while rst_n=0.

Configuration
REQ-027 Macro RISCV_RF_BYPASS_EN SHALL control write-to-read forwarding.
REQ-028 With RISCV_RF_BYPASS_EN defined, a read address equal to wb_rd_addr SHALL return wb_data combinationally in the same cycle. This applies only when wb_we=1, wb_rd_addr!=0 and rf_ready=1, and applies per port.
REQ-029 Without RISCV_RF_BYPASS_EN, reads SHALL return the stored (pre-write) value in the write cycle and the new value only from the next cycle.

Verification
REQ-030 Reset release, sample rf_ready each cycle -> rf_ready=0 for 30 posedges, 1 after the 31st; rs1_addr=5 reads 0 throughout INIT.
REQ-031 Write x7=64'hDEAD_BEEF_0123_4567, next cycle rs1_addr=rs2_addr=7 -> both ports return 64'hDEAD_BEEF_0123_4567.
REQ-032 Write x0=64'hFFFF_FFFF_FFFF_FFFF, then read x0 -> 64'h0; no other entry changed.
REQ-033 Same cycle: wb_we=1, rd=3, data=64'h55, rs2_addr=3 (x3 previously 64'h11) -> rs2_data=64'h55 with bypass, 64'h11 without; 64'h55 next cycle in both builds.
REQ-034 Fill x1..x31 with index values, assert rst_n for 1 cycle, release -> wb_we during INIT dropped; after rf_ready, every register reads 64'h0.
REQ-035 wb_we=1, rd=9 pulsed during cycle 10 of INIT -> x9 reads 64'h0 after rf_ready.
